data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Byte-addressed, parametrised data memory for the single-cycle core's load/store path, replacing the fixed 64-word, word-only, combinational-read memory. Supports RISC-V load/store widths (byte, half, word; signed and unsigned loads) with byte-lane write enables and misalignment/illegal-size detection. Uses a valid/ready request port and a fixed-latency response. Sits between the core's ALU address/rs2 outputs and the writeback mux.

## Interface
Parameters:
- ADDR_W, 8: byte-address width; depth = 2^(ADDR_W-2) 32-bit words.
- READ_LAT, 1: request-to-response latency in cycles; legal range 1..4.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low bytes used for SB/SH.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned or illegal; no memory change.

## Operation
- Accept = req_valid & req_ready at a posedge. Request fields sampled only at accept.
- funct3: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only). All other codes, and 100/101 with req_we=1, are illegal -> rsp_err=1.
- Alignment: H/HU need addr[0]=0; W needs addr[1:0]=00. Violation -> rsp_err=1.
- Store (legal): commits at the accept edge. Byte lanes written = addr[1:0] (SB), addr[1]*2..+1 (SH), all four (SW). Other lanes unchanged. Data is taken from req_wdata[7:0]/[15:0]/[31:0].
- Load (legal): word addr[ADDR_W-1:2] read at accept. Byte/half is selected by addr[1:0], then sign-extended (B, H) or zero-extended (BU, HU).
- Read after write: a load accepted after a store's accept edge returns the stored data.
- FSM: IDLE -> (accept) WAIT -> (count reaches READ_LAT-1) RESP -> IDLE, or RESP -> WAIT on a back-to-back accept. For READ_LAT=1, WAIT is skipped (IDLE -> RESP).
- Latency counter width is clog2(READ_LAT)+1 bits. It is cleared on accept.
- Memory contents are not cleared by rst. Initial contents: word0=17, word1=9, word2=25, all others 0.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, counter=0.
- Accept at edge T -> rsp_valid=1 for exactly the cycle after edge T+READ_LAT-1 (i.e. READ_LAT cycles later). rsp_rdata and rsp_err are valid only while rsp_valid=1 and are 0 otherwise.
- req_ready=1 in IDLE and in RESP; 0 in WAIT. Max throughput is one request per READ_LAT cycles.
- There is no response backpressure: the consumer must take rsp_valid when it is asserted.
- req_valid while req_ready=0 is ignored and is not queued.
- rst asserted mid-operation: the outstanding response is dropped and no rsp_valid is produced. A store already committed at its accept edge stays committed.
- Addresses beyond the depth cannot occur (ADDR_W bounds them); there is no wrap logic.

## Structure
- Shared package data_mem_pkg holds the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum (IDLE, WAIT, RESP). The core's decoder imports the same funct3 constants.
- One sub-module, mem_lane_ext: a combinational unit that does byte/half select plus sign/zero extension for loads and generates the write byte mask and replicated store data. The top holds the array, FSM, counter and response registers.

## Test plan
- Reset, READ_LAT=1: load W addr 0x00 -> rsp_rdata=17 one cycle after accept; load W 0x08 -> 25; rsp_err=0.
- SB 0xA5 to 0x05, then LB 0x05 -> 0xFFFFFFA5; LBU 0x05 -> 0x000000A5; LW 0x04 -> 0x0000A509 (lanes 0, 2, 3 keep word1=9).
- SH 0x8001 to 0x0A, then LH 0x0A -> 0xFFFF8001; LHU 0x0A -> 0x00008001; LW 0x08 -> 0x80010019.
- Misaligned LW 0x02, SH 0x03, and illegal funct3=011 -> rsp_err=1, rsp_rdata=0; LW 0x00 then still returns 17.
- READ_LAT=3: accept at cycle 0 -> rsp_valid only at cycle 3; req_ready=0 in cycles 1-2; a request held in cycles 1-2 is accepted in cycle 3, back-to-back.
- Assert rst in the cycle after a load is accepted (READ_LAT=3) -> no rsp_valid; outputs return to reset values; memory contents are unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared funct3 codes and LSU FSM states for the data memory load/store path.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lsu_state_e;

  // Unsigned loads have no store form; H/W need natural alignment.
  function automatic logic req_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic bad;
    unique case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = a[0];
      F3_W:    bad = |a;
      F3_BU:   bad = we;
      F3_HU:   bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Valid/ready request and fixed-latency response bundle between core and LSU.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lane_ext.sv
// Byte/half lane select with sign/zero extension, plus store byte mask.
module mem_lane_ext
  import data_mem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] rdata_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic        err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;
  logic [3:0]  mask_raw;

  assign err_o = req_bad(we_i, funct3_i, addr_lo_i);

  always_comb begin
    byte_sel = rword_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = rword_i[7:0];
      2'd1: byte_sel = rword_i[15:8];
      2'd2: byte_sel = rword_i[23:16];
      2'd3: byte_sel = rword_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16]
                            : rword_i[15:0];
  end

  always_comb begin
    ld_ext   = '0;
    mask_raw = '0;
    wdata_o  = wdata_i;
    case (funct3_i)
      F3_B: begin
        ld_ext   = {{24{byte_sel[7]}}, byte_sel};
        mask_raw = 4'b0001 << addr_lo_i;
        wdata_o  = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        ld_ext   = {{16{half_sel[15]}}, half_sel};
        mask_raw = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        ld_ext   = rword_i;
        mask_raw = 4'b1111;
      end
      F3_BU:   ld_ext = {24'b0, byte_sel};
      F3_HU:   ld_ext = {16'b0, half_sel};
      default: ld_ext = '0;
    endcase
  end

  assign rdata_o = (err_o | we_i) ? '0 : ld_ext;
  assign wmask_o = (we_i & ~err_o) ? mask_raw : 4'b0;

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with sized loads/stores and fixed read latency.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  data_mem_lsu_if.slave mem_if
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int CNT_W = $clog2(READ_LAT) + 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(READ_LAT - 1);

  logic [31:0] mem_q [DEPTH] = '{
    0: 32'd17, 1: 32'd9, 2: 32'd25,
    default: 32'd0
  };

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ready_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;
  logic [31:0]      pend_rdata_q;
  logic             pend_err_q;

  logic              accept;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       ld_data;
  logic [3:0]        wmask;
  logic [31:0]       wdata_rep;
  logic              err;

  assign accept = mem_if.req_valid & ready_q;
  assign widx   = mem_if.req_addr[ADDR_W-1:2];
  assign cnt_d  = cnt_q + 1'b1;

  mem_lane_ext u_lane (
    .we_i      (mem_if.req_we),
    .funct3_i  (mem_if.req_funct3),
    .addr_lo_i (mem_if.req_addr[1:0]),
    .wdata_i   (mem_if.req_wdata),
    .rword_i   (mem_q[widx]),
    .rdata_o   (ld_data),
    .wmask_o   (wmask),
    .wdata_o   (wdata_rep),
    .err_o     (err)
  );

  // Array has no reset: stored data must survive rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept && wmask[i])
        mem_q[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            cnt_q        <= '0;
            pend_rdata_q <= ld_data;
            pend_err_q   <= err;
            if (READ_LAT == 1) begin
              state_q     <= RESP;
              ready_q     <= 1'b1;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= ld_data;
              rsp_err_q   <= err;
            end else begin
              state_q <= WAIT;
              ready_q <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d == LAST) begin
            state_q     <= RESP;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pend_rdata_q;
            rsp_err_q   <= pend_err_q;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_if.req_ready = ready_q;
  assign mem_if.rsp_valid = rsp_valid_q;
  assign mem_if.rsp_rdata = rsp_rdata_q;
  assign mem_if.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized and directed bench for data_mem_lsu at READ_LAT=1 and READ_LAT=3.
module tb_data_mem_lsu;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  byte unsigned mem_m [2][256];
  logic [2:0]   legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  always #5 clk = ~clk;

  data_mem_lsu_if #(.ADDR_W(8)) bus1 ();
  data_mem_lsu_if #(.ADDR_W(8)) bus3 ();

  data_mem_lsu #(.ADDR_W(8), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_if(bus1)
  );
  data_mem_lsu #(.ADDR_W(8), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_if(bus3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input bit d3, input logic v,
                     input logic we, input logic [2:0] f3,
                     input logic [7:0] a, input logic [31:0] wd);
    if (d3) begin
      bus3.req_valid = v; bus3.req_we = we;
      bus3.req_funct3 = f3; bus3.req_addr = a;
      bus3.req_wdata = wd;
    end else begin
      bus1.req_valid = v; bus1.req_we = we;
      bus1.req_funct3 = f3; bus1.req_addr = a;
      bus1.req_wdata = wd;
    end
  endtask

  // {ready, rsp_valid, rsp_err, rsp_rdata}
  function automatic logic [34:0] smp(input bit d3);
    if (d3)
      return {bus3.req_ready, bus3.rsp_valid,
              bus3.rsp_err, bus3.rsp_rdata};
    return {bus1.req_ready, bus1.rsp_valid,
            bus1.rsp_err, bus1.rsp_rdata};
  endfunction

  // Reference: little-endian byte array, sizes and extension by arithmetic.
  function automatic void model(input bit d3, input logic we,
                                input logic [2:0] f3,
                                input logic [7:0] a,
                                input logic [31:0] wd,
                                output logic [31:0] d,
                                output logic e);
    int     sz;
    longint v;
    d = '0;
    e = 1'b0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (sz == 0 || (we && f3 >= 3'd4) || (int'(a) % sz) != 0) begin
      e = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < sz; i++)
        mem_m[d3][int'(a) + i] = byte'((wd >> (8 * i)) & 32'hFF);
    end else begin
      v = 0;
      for (int i = sz - 1; i >= 0; i--)
        v = v * 256 + longint'(mem_m[d3][int'(a) + i]);
      if (f3 < 3'd4 && sz < 4 && v >= (64'sd1 <<< (8 * sz - 1)))
        v = v - (64'sd1 <<< (8 * sz));
      d = v[31:0];
    end
  endfunction

  task automatic xact(input bit d3, input logic we,
                      input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] got);
    logic [31:0] ed;
    logic        ee;
    logic [34:0] s;
    int          lat;
    lat = d3 ? 3 : 1;
    model(d3, we, f3, a, wd, ed, ee);
    s = smp(d3);
    chk("ready", 32'(s[34]), 32'd1);
    drv(d3, 1'b1, we, f3, a, wd);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) drv(d3, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
      s = smp(d3);
      if (k < lat) begin
        chk("busy", 32'(s[34]), 32'd0);
        chk("early_v", 32'(s[33]), 32'd0);
        chk("idle_d", s[31:0], 32'd0);
      end
    end
    chk("rsp_v", 32'(s[33]), 32'd1);
    chk("rsp_err", 32'(s[32]), 32'(ee));
    chk("rsp_d", s[31:0], ed);
    got = s[31:0];
  endtask

  task automatic chk_reset(input bit d3, input string tag);
    logic [34:0] s;
    s = smp(d3);
    chk({tag, "_rdy"}, 32'(s[34]), 32'd1);
    chk({tag, "_v"}, 32'(s[33]), 32'd0);
    chk({tag, "_e"}, 32'(s[32]), 32'd0);
    chk({tag, "_d"}, s[31:0], 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] ed;
    logic [31:0] ed2;
    logic        ee;
    logic [34:0] s;
    logic [2:0]  f3;
    logic [7:0]  a;
    bit          d3;

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 256; i++) mem_m[u][i] = 8'd0;
    for (int u = 0; u < 2; u++) begin
      mem_m[u][0] = 8'd17;
      mem_m[u][4] = 8'd9;
      mem_m[u][8] = 8'd25;
    end
    drv(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    drv(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);

    repeat (2) @(negedge clk);
    chk_reset(1'b0, "rst1");
    chk_reset(1'b1, "rst3");
    rst = 1'b0;
    @(negedge clk);

    xact(0, 0, F3_W, 8'h00, 0, got);
    chk("lw0", got, 32'd17);
    xact(0, 0, F3_W, 8'h08, 0, got);
    chk("lw8", got, 32'd25);
    xact(0, 1, F3_B, 8'h05, 32'h000000A5, got);
    xact(0, 0, F3_B, 8'h05, 0, got);
    chk("lb5", got, 32'hFFFFFFA5);
    xact(0, 0, F3_BU, 8'h05, 0, got);
    chk("lbu5", got, 32'h000000A5);
    xact(0, 0, F3_W, 8'h04, 0, got);
    chk("lw4", got, 32'h0000A509);
    xact(0, 1, F3_H, 8'h0A, 32'h00008001, got);
    xact(0, 0, F3_H, 8'h0A, 0, got);
    chk("lha", got, 32'hFFFF8001);
    xact(0, 0, F3_HU, 8'h0A, 0, got);
    chk("lhua", got, 32'h00008001);
    xact(0, 0, F3_W, 8'h08, 0, got);
    chk("lw8b", got, 32'h80010019);
    xact(0, 0, F3_W, 8'h02, 0, got);
    xact(0, 1, F3_H, 8'h03, 32'h1234, got);
    xact(0, 0, 3'b011, 8'h00, 0, got);
    xact(0, 1, F3_BU, 8'h00, 32'hFF, got);
    xact(0, 0, F3_W, 8'h00, 0, got);
    chk("lw0_after_err", got, 32'd17);

    // Second request held while busy is taken back-to-back from RESP.
    @(negedge clk);
    model(1, 0, F3_W, 8'h00, 0, ed, ee);
    model(1, 0, F3_W, 8'h08, 0, ed2, ee);
    drv(1, 1, 0, F3_W, 8'h00, 0);
    @(negedge clk);
    drv(1, 1, 0, F3_W, 8'h08, 0);
    for (int k = 1; k <= 2; k++) begin
      if (k == 2) @(negedge clk);
      s = smp(1);
      chk("b2b_busy", 32'(s[34]), 32'd0);
      chk("b2b_quiet", 32'(s[33]), 32'd0);
    end
    @(negedge clk);
    s = smp(1);
    chk("b2b_v1", 32'(s[33]), 32'd1);
    chk("b2b_rdy", 32'(s[34]), 32'd1);
    chk("b2b_d1", s[31:0], ed);
    chk("b2b_17", s[31:0], 32'd17);
    @(negedge clk);
    drv(1, 0, 0, 3'd0, 8'd0, 0);
    s = smp(1);
    chk("b2b_pulse", 32'(s[33]), 32'd0);
    chk("b2b_taken", 32'(s[34]), 32'd0);
    @(negedge clk);
    s = smp(1);
    chk("b2b_gap", 32'(s[33]), 32'd0);
    @(negedge clk);
    s = smp(1);
    chk("b2b_v2", 32'(s[33]), 32'd1);
    chk("b2b_d2", s[31:0], ed2);

    // Reset while a load is outstanding drops the response.
    xact(1, 1, F3_W, 8'h10, 32'hDEADBEEF, got);
    drv(1, 1, 0, F3_W, 8'h10, 0);
    @(negedge clk);
    drv(1, 0, 0, 3'd0, 8'd0, 0);
    rst = 1'b1;
    #1;
    chk_reset(1'b1, "midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      s = smp(1);
      chk("rst_drop", 32'(s[33]), 32'd0);
    end
    xact(1, 0, F3_W, 8'h10, 0, got);
    chk("rst_mem", got, 32'hDEADBEEF);
    xact(1, 0, F3_W, 8'h00, 0, got);
    chk("rst_mem0", got, 32'd17);

    for (int n = 0; n < 300; n++) begin
      d3 = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) != 0)
        f3 = legal_f3[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        a = 8'($urandom_range(0, 255));
      else
        a = 8'($urandom_range(0, 31));
      xact(d3, 1'($urandom_range(0, 1)), f3, a, $urandom, got);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
